logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (OR / NOR / NOT) between NREQ requesters.
- Round-robin arbitration, one operation accepted per cycle.
- Single-entry registered response buffer with valid/ready backpressure and a completed-operation counter.
- Sits between client blocks issuing bitwise ops and the shared gate datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, 2, requester-id width, must be >= clog2(NREQ)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_op  input  2*NREQ  opcode of requester i at bits [2i+1:2i]
- req_a  input  WIDTH*NREQ  operand A of requester i at bits [WIDTH*i +: WIDTH]
- req_b  input  WIDTH*NREQ  operand B of requester i at bits [WIDTH*i +: WIDTH]
- rsp_valid  output  1  response held in buffer
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  IDW  index of the requester that issued the op
- rsp_y  output  WIDTH  result
- rsp_err  output  1  illegal opcode flag
- op_count  output  16  number of accepted operations; wraps at 16'hFFFF -> 0

Behaviour:
- Opcodes:
  - 2'b00 OR: y = a | b
  - 2'b01 NOR: y = ~(a | b)
  - 2'b10 NOT: y = ~a, b ignored
  - 2'b11 illegal: y = 0, rsp_err = 1
- can_accept = !rsp_valid || rsp_ready (combinational).
- Arbitration:
  - Priority order starts at ptr and searches ptr, ptr+1, ... mod NREQ.
  - The first i with req_valid[i]=1 is the grant.
  - req_ready[i] = grant[i] & can_accept, combinational from inputs and state.
  - No grant when no req_valid bit is set.
- Transfer: a transfer happens when req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - rsp_valid <= 1, rsp_id <= i.
  - rsp_y and rsp_err are loaded from the logic unit.
  - ptr <= (i+1) mod NREQ.
  - op_count <= op_count+1.
- Latency: request accepted at edge k; its response is visible from the cycle after edge k. Throughput is 1 op/cycle while rsp_ready stays high.
- Response drain: rsp_valid & rsp_ready with no new transfer -> rsp_valid <= 0. rsp_id, rsp_y and rsp_err hold their last values.
- Simultaneous drain and accept: the buffer is overwritten with the new op and rsp_valid stays 1. No bubble, no loss.
- Backpressure: rsp_valid=1 and rsp_ready=0 -> all req_ready are 0. Buffer contents are frozen. ptr is unchanged.
- Requester rules:
  - A requester must hold valid/op/a/b stable until accepted.
  - The arbiter never drops a pending grant.
  - Starvation bound: any continuously valid requester is accepted within NREQ transfers.
- ptr changes only on a transfer.
- State machine, 2 states:
  - EMPTY (rsp_valid=0): transfer -> FULL, else stay.
  - FULL (rsp_valid=1): rsp_ready & !transfer -> EMPTY; otherwise stay, reloading on transfer.
- Reset, synchronous, has priority over all other activity including a mid-transfer or held response. Reset values:
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0.
  - ptr=0, so requester 0 has highest priority.
  - op_count=0, state=EMPTY.
  - req_ready is 0 during the reset cycle.
- op_count wrap: 16'hFFFF plus one accept -> 16'h0000. No sticky flag.

Decomposition:
- Package logic_unit_pkg holds:
  - Opcode constants OP_OR=2'b00, OP_NOR=2'b01, OP_NOT=2'b10, OP_ILL=2'b11, plus a 2-bit op typedef.
  - The two state encodings EMPTY and FULL.
- Sub-module bitwise_logic_unit: combinational, inputs op, a, b; outputs y, err.
  - WIDTH parameter.
  - Instantiated once, fed by the granted requester's fields through a NREQ:1 mux.
- The round-robin search stays inline in logic_unit_arbiter.

Test Plan:
1. Reset → outputs and single-requester ops.
   - Stimulus: rst high 2 cycles, then requester 2 issues OP_OR a=8'h0F, b=8'hF0.
   - Required: req_ready=4'b0100 in that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_y=8'hFF, rsp_err=0, op_count=1.
2. Round-robin fairness.
   - Stimulus: all four req_valid high continuously with rsp_ready=1, starting from ptr=0.
   - Required: grant order 0,1,2,3,0 on consecutive cycles and rsp_valid held high every cycle.
3. Opcodes and backpressure.
   - Stimulus: requester 1 issues OP_NOT a=8'hA5; rsp_ready=0 for 3 cycles while requester 0 is valid.
   - Required: rsp_y=8'h5A held stable and req_ready=0 throughout. When rsp_ready rises, requester 0 is accepted that same cycle.
4. Illegal opcode.
   - Stimulus: requester 3 issues op=2'b11 a=8'hFF b=8'hFF.
   - Required: rsp_y=8'h00, rsp_err=1, op_count increments.
5. NOR and reset mid-operation.
   - Stimulus: requester 0 issues OP_NOR a=8'h00 b=8'h01, giving rsp_y=8'hFE. Assert rst while rsp_valid=1 and rsp_ready=0.
   - Required: next cycle rsp_valid=0, op_count=0, ptr=0.
6. Counter wrap.
   - Stimulus: force or preload op_count to 16'hFFFE, then perform 3 accepts.
   - Required: sequence 16'hFFFF, 16'h0000, 16'h0001.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter slice.
//   op_t     : 2-bit opcode carried by each requester
//   OP_*     : opcode encodings understood by bitwise_logic_unit
//   state_t  : response-buffer occupancy (EMPTY / FULL)
package logic_unit_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_OR  = 2'b00;
   localparam op_t OP_NOR = 2'b01;
   localparam op_t OP_NOT = 2'b10;
   localparam op_t OP_ILL = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/bitwise_logic_unit.sv
// Combinational WIDTH-bit gate datapath shared by all requesters.
// Ports:
//   op  : opcode (OR / NOR / NOT / illegal)
//   a,b : operands (b ignored for NOT)
//   y   : result, zero for the illegal opcode
//   err : high for the illegal opcode
module bitwise_logic_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_OR:   y = a | b;
         OP_NOR:  y = ~(a | b);
         OP_NOT:  y = ~a;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters,
// with a single-entry registered response buffer and an accept counter.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b    : per-requester opcode and operands, packed by index
//   rsp_valid/rsp_ready   : response buffer handshake
//   rsp_id/rsp_y/rsp_err  : buffered requester index, result, illegal-op flag
//   op_count              : accepted operations, wraps at 16 bits
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_y,
   output logic                  rsp_err,
   output logic [15:0]           op_count
);

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   gidx;
   logic             found;
   logic [NREQ-1:0]  grant;
   logic             can_accept;
   logic             xfer;
   op_t              sel_op;
   logic [WIDTH-1:0] sel_a, sel_b, unit_y;
   logic             unit_err;

   assign rsp_valid  = (state_q == FULL);
   // The buffer can take a new op if empty or draining this very cycle.
   assign can_accept = !rsp_valid || rsp_ready;

   // Search ptr, ptr+1, ... (mod NREQ); first valid requester wins.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gidx  = IDW'(idx);
         end
      end
      grant = '0;
      if (found) grant[gidx] = 1'b1;
   end

   // rst gates ready so no requester sees an accept during the reset cycle.
   assign xfer      = found && can_accept && !rst;
   assign req_ready = xfer ? grant : '0;

   assign sel_op = req_op[2*int'(gidx) +: 2];
   assign sel_a  = req_a[WIDTH*int'(gidx) +: WIDTH];
   assign sel_b  = req_b[WIDTH*int'(gidx) +: WIDTH];

   bitwise_logic_unit #(.WIDTH(WIDTH)) u_unit (
      .op  (sel_op),
      .a   (sel_a),
      .b   (sel_b),
      .y   (unit_y),
      .err (unit_err)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (xfer) state_d = FULL;
         FULL:    if (rsp_ready && !xfer) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         ptr_q    <= '0;
         rsp_id   <= '0;
         rsp_y    <= '0;
         rsp_err  <= 1'b0;
         op_count <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            rsp_id   <= gidx;
            rsp_y    <= unit_y;
            rsp_err  <= unit_err;
            ptr_q    <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            op_count <= op_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: stimulus pushes expected responses,
// a forked monitor pops and compares on every response handshake.
module tb_logic_unit_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [2*NREQ-1:0]     req_op = '0;
   logic [WIDTH*NREQ-1:0] req_a = '0;
   logic [WIDTH*NREQ-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_y;
   logic                  rsp_err;
   logic [15:0]           op_count;

   always #5 clk = ~clk;

   logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_err   (rsp_err),
      .op_count  (op_count)
   );

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] y;
      logic             err;
      logic [15:0]      cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_cnt  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[2*r +: 2]       = op;
      req_a[WIDTH*r +: WIDTH] = a;
      req_b[WIDTH*r +: WIDTH] = b;
   endtask

   // One cycle: at the falling edge check req_ready (and rsp_valid unless
   // exp_v==2), optionally record the expected response, then move to
   // just after the next rising edge.
   task automatic step(input logic [3:0] exp_rdy, input int exp_v, input bit push,
                       input logic [1:0] id, input logic [7:0] y, input logic err);
      exp_t e;
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_v != 2) chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (push) begin
         exp_cnt = exp_cnt + 16'd1;
         e = '{id: id, y: y, err: err, cnt: exp_cnt};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected_rsp", 32'(rsp_id), 32'hFFFF);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("sb_rsp_id",   32'(rsp_id),   32'(e.id));
                  chk("sb_rsp_y",    32'(rsp_y),    32'(e.y));
                  chk("sb_rsp_err",  32'(rsp_err),  32'(e.err));
                  chk("sb_op_count", 32'(op_count), 32'(e.cnt));
               end
            end
         end
         begin
            #1_500_000;
            $display("FAIL watchdog timeout actual=running required=finished");
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "watchdog");
         end
      join_none

      // 1. reset values, single requester OR
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id",    32'(rsp_id),    0);
      chk("rst_rsp_y",     32'(rsp_y),     0);
      chk("rst_rsp_err",   32'(rsp_err),   0);
      chk("rst_op_count",  32'(op_count),  0);
      set_req(2, 2'b00, 8'h0F, 8'hF0);
      req_valid = 4'b0100;
      step(4'b0100, 0, 1, 2'd2, 8'hFF, 1'b0);
      req_valid = '0;
      chk("t1_rsp_valid", 32'(rsp_valid), 1);
      chk("t1_rsp_id",    32'(rsp_id),    2);
      chk("t1_rsp_y",     32'(rsp_y),     32'hFF);
      chk("t1_op_count",  32'(op_count),  1);
      step(4'b0000, 1, 0, 0, 0, 0);

      // 2. round robin from ptr=0 (fresh reset), all valid, y = a
      rst = 1'b1; sb.delete(); exp_cnt = '0;
      @(posedge clk); #1 rst = 1'b0;
      set_req(0, 2'b00, 8'h00, 8'h00);
      set_req(1, 2'b00, 8'h11, 8'h00);
      set_req(2, 2'b00, 8'h22, 8'h00);
      set_req(3, 2'b00, 8'h33, 8'h00);
      req_valid = 4'b1111;
      step(4'b0001, 0, 1, 2'd0, 8'h00, 1'b0);
      step(4'b0010, 1, 1, 2'd1, 8'h11, 1'b0);
      step(4'b0100, 1, 1, 2'd2, 8'h22, 1'b0);
      step(4'b1000, 1, 1, 2'd3, 8'h33, 1'b0);
      step(4'b0001, 1, 1, 2'd0, 8'h00, 1'b0);
      req_valid = '0;
      step(4'b0000, 1, 0, 0, 0, 0);

      // 3. NOT with backpressure; ptr is now 1
      set_req(1, 2'b10, 8'hA5, 8'hFF);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      step(4'b0010, 0, 1, 2'd1, 8'h5A, 1'b0);
      set_req(0, 2'b00, 8'h30, 8'h03);
      req_valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         chk("t3_held_y", 32'(rsp_y), 32'h5A);
         step(4'b0000, 1, 0, 0, 0, 0);
      end
      rsp_ready = 1'b1;
      step(4'b0001, 1, 1, 2'd0, 8'h33, 1'b0);
      req_valid = '0;
      step(4'b0000, 1, 0, 0, 0, 0);

      // 4. illegal opcode; ptr is 1, requester 3 is the only one valid
      set_req(3, 2'b11, 8'hFF, 8'hFF);
      req_valid = 4'b1000;
      step(4'b1000, 0, 1, 2'd3, 8'h00, 1'b1);
      req_valid = '0;
      chk("t4_op_count", 32'(op_count), 32'(exp_cnt));
      step(4'b0000, 1, 0, 0, 0, 0);

      // 5. NOR then reset while the response is held
      set_req(0, 2'b01, 8'h00, 8'h01);
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      step(4'b0001, 0, 1, 2'd0, 8'hFE, 1'b0);
      req_valid = '0;
      chk("t5_rsp_y", 32'(rsp_y), 32'hFE);
      rst = 1'b1;
      req_valid = 4'b0010;
      sb.delete(); exp_cnt = '0;
      step(4'b0000, 1, 0, 0, 0, 0);
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_op_count",  32'(op_count),  0);
      chk("t5_rsp_y",     32'(rsp_y),     0);

      // 6. counter wrap via continuous accepts; first grant 0 shows ptr=0
      for (int r = 0; r < NREQ; r++) set_req(r, 2'b00, 8'h0F, 8'hF0);
      req_valid = 4'b1111;
      for (int i = 0; i <= 65536; i++) begin
         logic [3:0] g;
         g = 4'(1 << (i % 4));
         if (i >= 65534) chk("t6_op_count", 32'(op_count), 32'(i[15:0]));
         step(g, (i == 0) ? 0 : 1, 1, 2'(i % 4), 8'hFF, 1'b0);
      end
      req_valid = '0;
      chk("t6_op_count_final", 32'(op_count), 32'h0001);
      step(4'b0000, 1, 0, 0, 0, 0);
      chk("sb_drained", 32'(sb.size()), 0);
      chk("end_rsp_valid", 32'(rsp_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
